reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Parametrised successor to the single-port processor register file: one write port and two independent read ports, for dual-operand instruction issue.
- Synchronous reads, 1-cycle latency, with write-to-read bypass.
- After reset, an init FSM clears the array one entry per cycle, so the storage stays RAM-inferable.
- Sits between decode (read addresses) and writeback (result write).

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clkout  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ready  out  1  high once init clear is complete.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data (writeback result).
- rd0_en  in  1  read port 0 request.
- rd0_addr  in  ADDR_W  read port 0 address.
- rd0_data  out  DATA_W  read port 0 data; registered.
- rd0_valid  out  1  rd0_data valid, one cycle after the request.
- rd1_en, rd1_addr, rd1_data, rd1_valid: identical to port 0, for port 1.

Behaviour:
- Interface: one clock, clkout; reset rst_n, synchronous and active-low.
- Reset (rst_n=0 sampled at an edge):
  - ready=0, rd0_valid=rd1_valid=0, rd0_data=rd1_data=0.
  - Init counter is set to 0; FSM goes to INIT.
  - Array contents are not touched during reset itself.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle writes 0 to array[cnt], then cnt increments.
  - When cnt==DEPTH-1 is written, the FSM moves to RUN next cycle and ready=1 from that edge.
  - Init takes exactly DEPTH cycles after rst_n rises.
  - wr_en, rd0_en and rd1_en are ignored; rd*_valid stays 0.
- RUN, write:
  - wr_en=1 writes wr_data to array[wr_addr] at the edge.
  - No write in the same cycle as reset.
- RUN, read:
  - rdN_en=1 at edge k gives rdN_valid=1 and rdN_data=array[rdN_addr] after edge k.
  - rdN_en=0 gives rdN_valid=0 next cycle; rdN_data holds its last value.
- Bypass: if wr_en and rdN_en are both 1 in the same cycle and wr_addr==rdN_addr, rdN_data returns wr_data (write-first). This holds for both ports independently.
- Both ports may read the same address in the same cycle; each returns identical data.
- Reset asserted mid-init or mid-operation:
  - Restarts INIT from cnt=0 and drops ready the following edge.
  - Any in-flight read valid is cleared.
- No X on outputs after reset; addresses are always in range (power-of-two DEPTH).

Optional Feature:
- Macro: REG_FILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including the bypass case where wr_addr==0.
  - INIT still walks all DEPTH entries.
- Undefined: address 0 is an ordinary register.

Decomposition:
- Shared package proc_pkg:
  - REG_DATA_W and REG_DEPTH default constants.
  - typedef enum logic [0:0] {ST_INIT, ST_RUN} rf_state_t.
- One natural sub-module, reg_file_rd_port:
  - Holds the registered read data, the valid flop and the bypass compare.
  - Instantiated twice.
  - Array and FSM stay in the top module.

Test Plan:
- Init: rst_n low for 2 cycles, then high → ready=0 for exactly 32 cycles, 1 on cycle 32. Reads after that return 0 for all 32 addresses.
- Write/read: write 0xDEADBEEF to r5 and 0x12345678 to r9, then read r5 on port 0 and r9 on port 1 in the same cycle → next cycle rd0_data=0xDEADBEEF, rd1_data=0x12345678, both valids=1.
- Bypass: r7 holds 0x1; same cycle write r7=0xCAFEF00D and read r7 on both ports → both return 0xCAFEF00D. A read the following cycle also returns 0xCAFEF00D.
- Ignore during init: issue wr_en to r3=0xFFFFFFFF and rd0_en during INIT → rd0_valid stays 0. After ready, r3 reads 0.
- Reset mid-operation: write r4=0xA5A5A5A5, assert rst_n low for 1 cycle → ready drops, valids clear, init reruns 32 cycles. r4 then reads 0.
- R0 (macro defined): write r0=0x55 with a simultaneous read of r0 → returns 0, and a later read of r0 also returns 0. With the macro undefined, both reads return 0x55.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor register file: default sizes and
// the init/run state encoding used by reg_file_2r1w.
package proc_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_DEPTH  = 32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One synchronous read port of the register file: registered read data,
// valid flag and write-first bypass from the write port.
// Optional feature macro: REG_FILE_R0_ZERO_EN (address 0 always reads zero).
module reg_file_rd_port
  import proc_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_d, rd_valid_q;
  logic              hit_s;
  logic              zero_sel_s;

  // Address 0 is forced to zero only when the hardwired-zero register is built in.
  always_comb begin
`ifdef REG_FILE_R0_ZERO_EN
    zero_sel_s = (rd_addr == {ADDR_W{1'b0}});
`else
    zero_sel_s = 1'b0;
`endif
  end

  // Select next read data (zero / bypassed write / array) and next valid.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    hit_s      = wr_en && (wr_addr == rd_addr);
    if (run && rd_en) begin
      rd_valid_d = 1'b1;
      if (zero_sel_s) begin
        rd_data_d = {DATA_W{1'b0}};
      end else if (hit_s) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = arr_data;
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Output registers; data holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with synchronous reads, write-first
// bypass and a post-reset init walk that zeroes every entry, keeping the
// storage itself reset-free and RAM-inferable.
// Optional feature macro: REG_FILE_R0_ZERO_EN (register 0 hardwired to zero).
module reg_file_2r1w
  import proc_pkg::*;
#(
  parameter  int DATA_W = REG_DATA_W,
  parameter  int DEPTH  = REG_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clkout,
  input  logic              rst_n,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_t         state_d, state_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              ready_d, ready_q;
  logic              arr_we_s;
  logic [ADDR_W-1:0] arr_waddr_s;
  logic [DATA_W-1:0] arr_wdata_s;
  logic              wr_ok_s;
  logic              run_s;

  // Writes to address 0 are dropped when register 0 is hardwired zero.
  always_comb begin
`ifdef REG_FILE_R0_ZERO_EN
    wr_ok_s = (wr_addr != {ADDR_W{1'b0}});
`else
    wr_ok_s = 1'b1;
`endif
  end

  // Init/run FSM: walks the clear counter, then steers user writes to the array.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    arr_we_s    = 1'b0;
    arr_waddr_s = wr_addr;
    arr_wdata_s = wr_data;
    case (state_q)
      ST_INIT: begin
        arr_we_s    = 1'b1;
        arr_waddr_s = cnt_q;
        arr_wdata_s = {DATA_W{1'b0}};
        cnt_d       = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        if (wr_en && wr_ok_s) begin
          arr_we_s = 1'b1;
        end else begin
          arr_we_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {ADDR_W{1'b0}};
        ready_d = 1'b0;
      end
    endcase
  end

  // FSM, clear counter and ready flag; reset restarts the init walk.
  always_ff @(posedge clkout) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= {ADDR_W{1'b0}};
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage array: no reset so it maps onto RAM; untouched while reset is held.
  always_ff @(posedge clkout) begin
    if (rst_n && arr_we_s) begin
      mem[arr_waddr_s] <= arr_wdata_s;
    end
  end

  assign run_s = (state_q == ST_RUN);
  assign ready = ready_q;

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd0 (
    .clk      (clkout),
    .rst_n    (rst_n),
    .run      (run_s),
    .rd_en    (rd0_en),
    .rd_addr  (rd0_addr),
    .arr_data (mem[rd0_addr]),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd0_data),
    .rd_valid (rd0_valid)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd1 (
    .clk      (clkout),
    .rst_n    (rst_n),
    .run      (run_s),
    .rd_en    (rd1_en),
    .rd_addr  (rd1_addr),
    .arr_data (mem[rd1_addr]),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd1_data),
    .rd_valid (rd1_valid)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus random
// traffic, compared every cycle against a behavioural register-file model.
module tb_reg_file_2r1w;

  localparam int DW = 32;
  localparam int DP = 32;
  localparam int AW = 5;
`ifdef REG_FILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic          clkout = 1'b0;
  logic          rst_n = 1'b0;
  logic          ready;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd0_en = 1'b0;
  logic [AW-1:0] rd0_addr = '0;
  logic [DW-1:0] rd0_data;
  logic          rd0_valid;
  logic          rd1_en = 1'b0;
  logic [AW-1:0] rd1_addr = '0;
  logic [DW-1:0] rd1_data;
  logic          rd1_valid;

  reg_file_2r1w dut (
    .clkout(clkout), .rst_n(rst_n), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid)
  );

  always #5 clkout = ~clkout;

  // Behavioural model: contents, remaining init cycles, expected outputs.
  logic [DW-1:0] m_mem [DP];
  int            m_init_left = DP;
  logic          m_ready = 1'b0;
  logic          m_v0 = 1'b0, m_v1 = 1'b0;
  logic [DW-1:0] m_d0 = '0, m_d1 = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic we,
                                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (R0Z && a == 0) return '0;
    if (we && wa == a) return wd;
    return m_mem[a];
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re0, input logic [AW-1:0] a0,
                      input logic re1, input logic [AW-1:0] a1);
    rst_n = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd0_en = re0; rd0_addr = a0; rd1_en = re1; rd1_addr = a1;
    @(posedge clkout);
    if (!rst) begin
      m_init_left = DP; m_ready = 1'b0;
      m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = '0; m_d1 = '0;
    end else if (m_init_left > 0) begin
      m_init_left--;
      m_v0 = 1'b0; m_v1 = 1'b0;
      if (m_init_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
      end
    end else begin
      m_v0 = re0; m_v1 = re1;
      if (re0) m_d0 = model_read(a0, we, wa, wd);
      if (re1) m_d1 = model_read(a1, we, wa, wd);
      if (we && !(R0Z && wa == 0)) m_mem[wa] = wd;
    end
    @(negedge clkout);
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    chk("rd0_valid", {31'd0, rd0_valid}, {31'd0, m_v0});
    chk("rd1_valid", {31'd0, rd1_valid}, {31'd0, m_v1});
    chk("rd0_data", rd0_data, m_d0);
    chk("rd1_data", rd1_data, m_d1);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Run with noise on all request inputs until ready; returns cycles taken.
  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'd3);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] exp_r0;

    // Init after reset held for two cycles.
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_rd0_data", rd0_data, 32'd0);
    wait_ready(n);
    chk("init_cycles", n, 32'd32);

    // Every entry reads zero, including r3 written during init.
    for (int i = 0; i < DP; i++) step(1'b1, 1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(DP - 1 - i));
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0);
    chk("r3_after_init", rd0_data, 32'd0);

    // Write then dual read.
    step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 5'd9, 32'h1234_5678, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd9);
    chk("r5_port0", rd0_data, 32'hDEAD_BEEF);
    chk("r9_port1", rd1_data, 32'h1234_5678);
    chk("both_valid", {30'd0, rd0_valid, rd1_valid}, 32'd3);
    idle();
    chk("data_hold", rd0_data, 32'hDEAD_BEEF);

    // Bypass on both ports.
    step(1'b1, 1'b1, 5'd7, 32'h0000_0001, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 5'd7, 32'hCAFE_F00D, 1'b1, 5'd7, 1'b1, 5'd7);
    chk("bypass_p0", rd0_data, 32'hCAFE_F00D);
    chk("bypass_p1", rd1_data, 32'hCAFE_F00D);
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0);
    chk("after_bypass", rd0_data, 32'hCAFE_F00D);

    // Register 0 behaviour.
    exp_r0 = R0Z ? 32'd0 : 32'h0000_0055;
    step(1'b1, 1'b1, 5'd0, 32'h0000_0055, 1'b1, 5'd0, 1'b0, '0);
    chk("r0_bypass", rd0_data, exp_r0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd0);
    chk("r0_later", rd1_data, exp_r0);

    // Reset in mid-operation.
    step(1'b1, 1'b1, 5'd4, 32'hA5A5_A5A5, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd4, 1'b1, 5'd4);
    chk("r4_before_rst", rd0_data, 32'hA5A5_A5A5);
    step(1'b0, 1'b1, 5'd4, 32'h1111_1111, 1'b1, 5'd4, 1'b1, 5'd4);
    chk("midrst_state", {29'd0, ready, rd0_valid, rd1_valid}, 32'd0);
    wait_ready(n);
    chk("reinit_cycles", n, 32'd32);
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd4, 1'b0, '0);
    chk("r4_after_rst", rd0_data, 32'd0);

    // Random traffic, addresses biased to a small window for frequent bypass hits.
    for (int k = 0; k < 1500; k++) begin
      logic narrow;
      narrow = ($urandom_range(0, 1) == 0);
      step(($urandom_range(0, 199) != 0),
           1'(($urandom_range(0, 1))),
           narrow ? AW'($urandom_range(0, 3)) : AW'($urandom),
           $urandom,
           1'(($urandom_range(0, 3) != 0)),
           narrow ? AW'($urandom_range(0, 3)) : AW'($urandom),
           1'(($urandom_range(0, 3) != 0)),
           narrow ? AW'($urandom_range(0, 3)) : AW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
